// File: rtl/dft_pkg.sv
// Shared definitions for the DFT frame sequencer: sizes, float constants,
// FSM state encoding and the 4-bit index bit-reversal helper.
package dft_pkg;

    localparam int N_PTS = 16;
    localparam int W     = 32;

    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        WAIT_CORE,
        DONE
    } state_t;

    function automatic logic [3:0] bitrev4(input logic [3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/dft_sample_mux.sv
// Selects one sample from the captured frame for the current stream count.
// Optional feature macro: DFT_BITREV_ORDER_EN (bit-reversed emission order).
module dft_sample_mux #(
    parameter int N_PTS = dft_pkg::N_PTS,
    parameter int W     = dft_pkg::W
) (
    input  logic [N_PTS*W-1:0] frame,
    input  logic [3:0]         cnt,
    output logic [W-1:0]       sample,
    output logic [3:0]         idx
);
    import dft_pkg::*;

    logic [W-1:0] words [N_PTS];

    always_comb begin
        for (int unsigned j = 0; j < N_PTS; j++) begin
            words[j] = frame[j*W +: W];
        end
    end

`ifdef DFT_BITREV_ORDER_EN
    assign idx = bitrev4(cnt);
`else
    assign idx = cnt;
`endif

    assign sample = words[idx];

endmodule

// File: rtl/dft_frame_sequencer.sv
// Captures a 16-point test frame and streams it to a DFT core, then waits for
// the core's completion pulse. Optional feature macro: DFT_BITREV_ORDER_EN.
module dft_frame_sequencer #(
    parameter int N_PTS = dft_pkg::N_PTS,
    parameter int W     = dft_pkg::W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [2:0]         set_sel_i,
    input  logic               abort_i,
    output logic [2:0]         set_sel_o,
    input  logic [N_PTS*W-1:0] samples_i,
    output logic [W-1:0]       sample_o,
    output logic [3:0]         sample_idx_o,
    output logic               sample_valid_o,
    input  logic               sample_ready_i,
    output logic               sample_last_o,
    input  logic               core_done_i,
    output logic               busy_o,
    output logic               frame_done_o
);
    import dft_pkg::*;

    state_t             state, state_nxt;
    logic [3:0]         cnt;
    logic [N_PTS*W-1:0] frame;
    logic               valid_q;
    logic               xfer;
    logic               cnt_last;

    assign xfer     = valid_q && sample_ready_i;
    assign cnt_last = (cnt == 4'(N_PTS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      if (start_i) state_nxt = LOAD;
                LOAD:      state_nxt = STREAM;
                STREAM:    if (xfer && cnt_last) state_nxt = WAIT_CORE;
                WAIT_CORE: if (core_done_i) state_nxt = DONE;
                DONE:      state_nxt = IDLE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // Abort also masks the completion pulse if it lands in DONE.
    always_comb begin
        busy_o       = (state != IDLE);
        frame_done_o = (state == DONE) && !abort_i;
    end

    // Valid is registered, so the first beat appears one cycle after STREAM entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_sel_o <= '0;
            frame     <= {N_PTS{FP_ZERO}};
            cnt       <= '0;
            valid_q   <= 1'b0;
        end else if (abort_i) begin
            cnt     <= '0;
            valid_q <= 1'b0;
        end else begin
            if (state == IDLE && start_i) begin
                set_sel_o <= set_sel_i;
            end
            if (state == LOAD) begin
                frame <= samples_i;
            end
            if (state == STREAM) begin
                if (xfer) begin
                    cnt <= cnt + 4'd1;
                end
                valid_q <= !(xfer && cnt_last);
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    dft_sample_mux #(
        .N_PTS (N_PTS),
        .W     (W)
    ) u_mux (
        .frame  (frame),
        .cnt    (cnt),
        .sample (sample_o),
        .idx    (sample_idx_o)
    );

    assign sample_valid_o = valid_q;
    assign sample_last_o  = valid_q && cnt_last;

endmodule

// File: tb/tb_dft_frame_sequencer.sv
// Self-checking bench for dft_frame_sequencer; honours DFT_BITREV_ORDER_EN
// in its reference ordering model.
module tb_dft_frame_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start_i;
    logic [2:0]   set_sel_i;
    logic         abort_i;
    logic [2:0]   set_sel_o;
    logic [511:0] samples_i;
    logic [31:0]  sample_o;
    logic [3:0]   sample_idx_o;
    logic         sample_valid_o;
    logic         sample_ready_i;
    logic         sample_last_o;
    logic         core_done_i;
    logic         busy_o;
    logic         frame_done_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_val [16];
    logic [3:0]  exp_idx [16];

    dft_frame_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .set_sel_i      (set_sel_i),
        .abort_i        (abort_i),
        .set_sel_o      (set_sel_o),
        .samples_i      (samples_i),
        .sample_o       (sample_o),
        .sample_idx_o   (sample_idx_o),
        .sample_valid_o (sample_valid_o),
        .sample_ready_i (sample_ready_i),
        .sample_last_o  (sample_last_o),
        .core_done_i    (core_done_i),
        .busy_o         (busy_o),
        .frame_done_o   (frame_done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Emission order: beat k carries natural sample model_order(k).
    function automatic int model_order(input int k);
        int r;
`ifdef DFT_BITREV_ORDER_EN
        r = 0;
        for (int b = 0; b < 4; b++) begin
            if (((k >> b) & 1) == 1) r = r + (1 << (3 - b));
        end
`else
        r = k;
`endif
        return r;
    endfunction

    function automatic logic [31:0] fp_of_int(input int v);
        int e;
        logic [7:0]  ex;
        logic [22:0] man;
        if (v == 0) return 32'h0000_0000;
        e = 0;
        while ((1 << (e + 1)) <= v) e++;
        ex  = 8'(127 + e);
        man = 23'((v - (1 << e)) << (23 - e));
        return {1'b0, ex, man};
    endfunction

    function automatic logic [511:0] rand_frame();
        logic [511:0] r;
        for (int j = 0; j < 16; j++) r[j*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic build_expected(input logic [511:0] s);
        int n;
        for (int k = 0; k < 16; k++) begin
            n = model_order(k);
            exp_idx[k] = 4'(n);
            exp_val[k] = s[n*32 +: 32];
        end
    endtask

    // Accepts start, then advances to the first valid beat (2 edges after acceptance).
    task automatic start_frame(input logic [2:0] sel, input logic [511:0] data);
        build_expected(data);
        samples_i = data;
        set_sel_i = sel;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
        set_sel_i = ~sel;
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_err++; $display("FAIL busy_after_start: got %b want 1", busy_o);
        end
        n_cmp++;
        if (set_sel_o !== sel) begin
            n_err++; $display("FAIL set_sel_latch: got %b want %b", set_sel_o, sel);
        end
        n_cmp++;
        if (sample_valid_o !== 1'b0) begin
            n_err++; $display("FAIL valid_cycle1: got %b want 0", sample_valid_o);
        end
        tick();
        samples_i = rand_frame();
        start_i   = 1'b1;
        n_cmp++;
        if (sample_valid_o !== 1'b0) begin
            n_err++; $display("FAIL valid_cycle2_early: got %b want 0", sample_valid_o);
        end
        tick();
        start_i = 1'b0;
        n_cmp++;
        if (sample_valid_o !== 1'b1) begin
            n_err++; $display("FAIL first_valid_latency: got %b want 1", sample_valid_o);
        end
        n_cmp++;
        if (set_sel_o !== sel) begin
            n_err++; $display("FAIL set_sel_hold: got %b want %b", set_sel_o, sel);
        end
    endtask

    // mode 0: ready always high, 1: pattern 1,0,0,1, 2: random.
    task automatic stream_frame(input int mode);
        int beats;
        int cycles;
        logic r;
        logic [3:0] pat;
        beats  = 0;
        cycles = 0;
        pat    = 4'b1001;
        while (beats < 16 && cycles < 300) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = pat[3 - (cycles % 4)];
                default: r = 1'($urandom_range(0, 1));
            endcase
            sample_ready_i = r;
            n_cmp++;
            if (sample_valid_o !== 1'b1) begin
                n_err++; $display("FAIL stream_valid beat %0d: got %b want 1", beats, sample_valid_o);
            end
            n_cmp++;
            if (sample_o !== exp_val[beats]) begin
                n_err++; $display("FAIL stream_data beat %0d: got %h want %h", beats, sample_o, exp_val[beats]);
            end
            n_cmp++;
            if (sample_idx_o !== exp_idx[beats]) begin
                n_err++; $display("FAIL stream_idx beat %0d: got %0d want %0d", beats, sample_idx_o, exp_idx[beats]);
            end
            n_cmp++;
            if (sample_last_o !== (beats == 15)) begin
                n_err++; $display("FAIL stream_last beat %0d: got %b want %b", beats, sample_last_o, beats == 15);
            end
            if (r) beats++;
            tick();
            cycles++;
        end
        sample_ready_i = 1'b0;
        n_cmp++;
        if (beats != 16) begin
            n_err++; $display("FAIL stream_beats: got %0d want 16 (cycle budget expired)", beats);
        end
        if (mode == 0) begin
            n_cmp++;
            if (cycles != 16) begin
                n_err++; $display("FAIL stream_throughput: got %0d cycles want 16", cycles);
            end
        end
        n_cmp++;
        if ({sample_valid_o, sample_last_o, busy_o, frame_done_o} !== 4'b0010) begin
            n_err++; $display("FAIL wait_core_state: got v/l/b/fd=%b want 0010",
                              {sample_valid_o, sample_last_o, busy_o, frame_done_o});
        end
    endtask

    task automatic finish_core();
        int gap;
        gap = $urandom_range(0, 3);
        for (int i = 0; i < gap; i++) begin
            tick();
            n_cmp++;
            if (frame_done_o !== 1'b0 || busy_o !== 1'b1) begin
                n_err++; $display("FAIL wait_core_hold: got fd=%b busy=%b want 0/1", frame_done_o, busy_o);
            end
        end
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        start_i     = 1'b1;
        n_cmp++;
        if (frame_done_o !== 1'b1 || busy_o !== 1'b1) begin
            n_err++; $display("FAIL done_pulse: got fd=%b busy=%b want 1/1", frame_done_o, busy_o);
        end
        tick();
        start_i = 1'b0;
        n_cmp++;
        if (frame_done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_err++; $display("FAIL done_to_idle: got fd=%b busy=%b want 0/0", frame_done_o, busy_o);
        end
        tick();
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++; $display("FAIL start_in_done_ignored: got busy=%b want 0", busy_o);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start_i = 1'b0; set_sel_i = '0; abort_i = 1'b0;
        samples_i = '0; sample_ready_i = 1'b0; core_done_i = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({set_sel_o, sample_o, sample_idx_o, sample_valid_o, sample_last_o, busy_o, frame_done_o} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got sel=%b s=%h i=%0d v=%b l=%b b=%b fd=%b want all 0",
                              set_sel_o, sample_o, sample_idx_o, sample_valid_o, sample_last_o, busy_o, frame_done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_ones_frame();
        logic [511:0] d;
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = 32'h3F80_0000;
        start_frame(3'b001, d);
        stream_frame(0);
        finish_core();
    endtask

    task automatic test_ramp();
        logic [511:0] d;
        for (int j = 0; j < 16; j++) d[j*32 +: 32] = fp_of_int(j);
        start_frame(3'b110, d);
        stream_frame(0);
        finish_core();
    endtask

    task automatic test_stall();
        start_frame(3'b011, rand_frame());
        stream_frame(1);
        finish_core();
        for (int t = 0; t < 3; t++) begin
            start_frame(3'($urandom_range(0, 7)), rand_frame());
            stream_frame(2);
            finish_core();
        end
    endtask

    task automatic test_abort();
        logic [511:0] d;
        d = rand_frame();
        start_frame(3'b101, d);
        sample_ready_i = 1'b1;
        for (int b = 0; b < 5; b++) begin
            n_cmp++;
            if (sample_o !== exp_val[b] || sample_idx_o !== exp_idx[b]) begin
                n_err++; $display("FAIL pre_abort beat %0d: got %h/%0d want %h/%0d",
                                  b, sample_o, sample_idx_o, exp_val[b], exp_idx[b]);
            end
            tick();
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        sample_ready_i = 1'b0;
        n_cmp++;
        if ({busy_o, sample_valid_o, frame_done_o} !== 3'b000) begin
            n_err++; $display("FAIL abort_idle: got b/v/fd=%b want 000", {busy_o, sample_valid_o, frame_done_o});
        end
        for (int i = 0; i < 4; i++) begin
            core_done_i = (i == 1);
            tick();
            n_cmp++;
            if (frame_done_o !== 1'b0 || busy_o !== 1'b0) begin
                n_err++; $display("FAIL abort_no_done: got fd=%b busy=%b want 0/0", frame_done_o, busy_o);
            end
        end
        core_done_i = 1'b0;
        abort_i = 1'b1;
        start_i = 1'b1;
        tick();
        abort_i = 1'b0;
        start_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b0) begin
            n_err++; $display("FAIL abort_beats_start: got busy=%b want 0", busy_o);
        end
        tick();
        start_frame(3'b010, rand_frame());
        stream_frame(0);
        finish_core();
    endtask

    task automatic test_reset_wait_core();
        start_frame(3'b111, rand_frame());
        stream_frame(0);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({set_sel_o, sample_o, sample_idx_o, sample_valid_o, sample_last_o, busy_o, frame_done_o} !== '0) begin
            n_err++; $display("FAIL async_reset: got sel=%b s=%h i=%0d v=%b l=%b b=%b fd=%b want all 0",
                              set_sel_o, sample_o, sample_idx_o, sample_valid_o, sample_last_o, busy_o, frame_done_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        core_done_i = 1'b1;
        tick();
        core_done_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_cmp++;
            if (frame_done_o !== 1'b0 || busy_o !== 1'b0) begin
                n_err++; $display("FAIL reset_no_done: got fd=%b busy=%b want 0/0", frame_done_o, busy_o);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_ones_frame();
        test_ramp();
        test_stall();
        test_abort();
        test_reset_wait_core();
        test_ramp();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
